// File: rtl/pipe_chain.sv
// Elastic register chain with collapsing bubbles, global stall, per-stage kill
// and a saturating count of killed entries. Stage 0 is the input stage.
module pipe_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNTW  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       stall,
  input  logic [DEPTH-1:0]           flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNTW-1:0]            kill_cnt
);

  localparam int OW = $clog2(DEPTH + 1);
  localparam int SW = CNTW + 5;
  localparam logic [SW-1:0] CNT_MAX = {{5{1'b0}}, {CNTW{1'b1}}};

  // Handshake: a transfer happens on a rising edge only when valid and ready
  // are both high in the preceding cycle; neither side waits on the other.
  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];

  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] src_d [DEPTH];
  logic [OW-1:0]    occ;
  logic [OW-1:0]    kills;
  logic [SW-1:0]    cnt_sum;
  logic             rdy_acc;

  // A stage is ready if anything downstream of it (or itself) is a bubble,
  // or the consumer takes the last entry.
  always_comb begin
    rdy_acc = out_ready | ~v[DEPTH-1];
    rdy[DEPTH-1] = rdy_acc;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      rdy_acc = rdy_acc | ~v[i];
      rdy[i] = rdy_acc;
    end
  end

  // A killed entry is replaced by a bubble on its way to the next stage.
  always_comb begin
    src_v[0] = in_valid;
    src_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_v[i] = v[i-1] & ~flush[i-1];
      src_d[i] = d[i-1];
    end
  end

  always_comb begin
    occ   = '0;
    kills = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ   = occ + OW'(v[i]);
      kills = kills + OW'(v[i] & flush[i]);
    end
    cnt_sum = {{5{1'b0}}, kill_cnt} + SW'(kills);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) d[i] <= '0;
      kill_cnt <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!stall && rdy[i]) begin
          v[i] <= src_v[i];
          d[i] <= src_d[i];
        end else if (flush[i]) begin
          v[i] <= 1'b0;
        end
      end
      kill_cnt <= (cnt_sum > CNT_MAX) ? CNT_MAX[CNTW-1:0] : cnt_sum[CNTW-1:0];
    end
  end

  assign in_ready  = rdy[0] & ~stall;
  assign out_valid = v[DEPTH-1] & ~flush[DEPTH-1] & ~stall;
  assign out_data  = d[DEPTH-1];
  assign occupancy = occ;

endmodule
